weight_ram_scheduler: RTL and testbench

Shares one weightRAM row-read port among NREQ LSTM gate engines (input, forget, output, candidate). Grants one requester at a time in round-robin order, then sweeps addresses 0..NROWS-1, presenting each registered RAM row with a valid/ready handshake. Sits between weightRAM and the gate matrix-vector units.

---
 rtl/weight_ram_scheduler.sv | 163 ++++++++++++++++
 tb/tb_weight_ram_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_ram_scheduler.sv
// weightRAM row-read scheduler: round-robin grant, then a full row sweep.
// Optional WRAM_STALL_CNT_EN adds a saturating back-pressure counter.
module weight_ram_scheduler #(
  parameter int BITWIDTH   = 18,
  parameter int NROWS      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NREQ       = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  output logic [NREQ-1:0]           grant,
  output logic [ADDR_WIDTH-1:0]     ram_address,
  input  logic [NROWS*BITWIDTH-1:0] ram_row,
  output logic [NROWS*BITWIDTH-1:0] row_data,
  output logic [ADDR_WIDTH-1:0]     row_index,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic                      sweep_done,
  output logic                      busy
`ifdef WRAM_STALL_CNT_EN
  ,
  output logic [15:0]               stall_count
`endif
);

  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(NROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [RW-1:0]   rr;
  logic [RW-1:0]   win;
  logic [NREQ-1:0] win_oh;
  logic            any_req;
  logic            xfer;
  logic            last_row;

  assign xfer     = (state == PRESENT) && row_valid && row_ready;
  assign last_row = (row_index == LAST);

  // Round-robin pick: scan above the last winner first, then wrap.
  always_comb begin
    win     = rr;
    win_oh  = '0;
    any_req = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!any_req && j > int'(rr) && req[j]) begin
        any_req   = 1'b1;
        win       = RW'(j);
        win_oh    = '0;
        win_oh[j] = 1'b1;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!any_req && j <= int'(rr) && req[j]) begin
        any_req   = 1'b1;
        win       = RW'(j);
        win_oh    = '0;
        win_oh[j] = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nx = FETCH;
        end
      end
      FETCH: begin
        state_nx = PRESENT;
      end
      PRESENT: begin
        if (xfer) begin
          state_nx = last_row ? IDLE : FETCH;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Status outputs; sweep_done rides on the last-row transfer.
  always_comb begin
    sweep_done = xfer && last_row;
    busy       = (state != IDLE);
  end

  // Grant, address and captured-row registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant       <= '0;
      rr          <= RW'(NREQ - 1);
      ram_address <= '0;
      row_data    <= '0;
      row_index   <= '0;
      row_valid   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant       <= win_oh;
            rr          <= win;
            ram_address <= '0;
          end
        end
        FETCH: begin
          row_data  <= ram_row;
          row_index <= ram_address;
          row_valid <= 1'b1;
        end
        PRESENT: begin
          if (xfer) begin
            row_valid <= 1'b0;
            if (last_row) begin
              grant <= '0;
            end else begin
              ram_address <= ram_address + ADDR_WIDTH'(1);
            end
          end
        end
        default: begin
          row_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef WRAM_STALL_CNT_EN
  // Count cycles a presented row waits on the consumer; saturate.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (row_valid && !row_ready &&
                 stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_weight_ram_scheduler.sv
// Scoreboard bench for weight_ram_scheduler.
// Expected rows come from a transaction-level round-robin model.
module tb_weight_ram_scheduler;

  localparam int BITWIDTH   = 18;
  localparam int NROWS      = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int NREQ       = 4;
  localparam int W          = NROWS * BITWIDTH;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [NREQ-1:0]       req   = '0;
  logic [NREQ-1:0]       grant;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [W-1:0]          ram_row;
  logic [W-1:0]          row_data;
  logic [ADDR_WIDTH-1:0] row_index;
  logic                  row_valid;
  logic                  row_ready;
  logic                  sweep_done;
  logic                  busy;
`ifdef WRAM_STALL_CNT_EN
  logic [15:0]           stall_count;
`endif

  logic rand_ready = 1'b0;
  logic rnd_ready  = 1'b1;
  logic ready_val  = 1'b1;

  assign row_ready = rand_ready ? rnd_ready : ready_val;

  typedef struct {
    logic [NREQ-1:0]       g;
    logic [ADDR_WIDTH-1:0] idx;
    logic [W-1:0]          data;
    logic                  done;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   last_w = NREQ - 1;

  function automatic logic [W-1:0] rowval(input int r);
    logic [BITWIDTH-1:0] v;
    v = BITWIDTH'(r);
    return {NROWS{v}};
  endfunction

  assign ram_row = rowval(int'(ram_address));

  weight_ram_scheduler #(
    .BITWIDTH  (BITWIDTH),
    .NROWS     (NROWS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .NREQ      (NREQ)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .grant      (grant),
    .ram_address(ram_address),
    .ram_row    (ram_row),
    .row_data   (row_data),
    .row_index  (row_index),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .sweep_done (sweep_done),
    .busy       (busy)
`ifdef WRAM_STALL_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    rnd_ready = ($urandom_range(3) != 0);
  end

  task automatic check(input string name,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out / unexpected event", name);
  endtask

  // Next owner: first set bit strictly after the previous owner, wrapping.
  function automatic int winner(input logic [NREQ-1:0] pat);
    for (int i = 1; i <= NREQ; i++) begin
      int c;
      c = (last_w + i) % NREQ;
      if (pat[c]) return c;
    end
    return -1;
  endfunction

  task automatic push_sweep(input logic [NREQ-1:0] pat);
    int   w;
    exp_t e;
    w      = winner(pat);
    last_w = w;
    for (int r = 0; r < NROWS; r++) begin
      e.g    = NREQ'(1) << w;
      e.idx  = ADDR_WIDTH'(r);
      e.data = rowval(r);
      e.done = (r == NROWS - 1);
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (sweep_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("wait_sweep_done");
  endtask

  task automatic wait_grant(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (grant != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("wait_grant");
  endtask

  // Monitor: every accepted row is popped and compared.
  always @(negedge clock) begin
    if (reset && row_valid && row_ready) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_row");
      end else begin
        mon_e = sb.pop_front();
        check("grant", W'(grant), W'(mon_e.g));
        check("row_index", W'(row_index), W'(mon_e.idx));
        check("row_data", row_data, mon_e.data);
        check("sweep_done", W'(sweep_done), W'(mon_e.done));
        check("ram_address", W'(ram_address), W'(mon_e.idx));
      end
    end else if (reset && sweep_done) begin
      fail_now("spurious_sweep_done");
    end
  end

  initial begin
    int n;
    bit ok;
    logic [15:0] stall0;
    logic [NREQ-1:0] pat;
    stall0 = '0;

    // Reset values
    repeat (2) @(negedge clock);
    check("rst_grant", W'(grant), '0);
    check("rst_addr", W'(ram_address), '0);
    check("rst_data", row_data, '0);
    check("rst_index", W'(row_index), '0);
    check("rst_valid", W'(row_valid), '0);
    check("rst_done", W'(sweep_done), '0);
    check("rst_busy", W'(busy), '0);
`ifdef WRAM_STALL_CNT_EN
    check("rst_stall", W'(stall_count), '0);
`endif
    reset = 1'b1;

    // Single requester, ready held high: timing of one sweep
    @(negedge clock);
    req = 4'b0001;
    push_sweep(req);
    wait_grant(10);
    check("t1_grant", W'(grant), W'(4'b0001));
    n = 0;
    ok = 1'b0;
    while (n < 100 && !ok) begin
      @(negedge clock);
      n++;
      ok = sweep_done;
    end
    check("t1_sweep_cycles", W'(n), W'(2 * NROWS - 1));
    req = '0;
    @(negedge clock);
    check("t1_busy_after", W'(busy), '0);

    // All requesters held: rotation over five sweeps
    req = 4'b1111;
    for (int k = 0; k < 5; k++) push_sweep(4'b1111);
    rand_ready = 1'b1;
    for (int k = 0; k < 5; k++) wait_done(2000);
    req = '0;
    @(negedge clock);

    // Back-pressure on row 7
    @(negedge clock);
    rand_ready = 1'b0;
    ready_val  = 1'b1;
    req = 4'b0100;
    push_sweep(req);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      ok = busy && !row_valid && ram_address == 7;
    end
    if (!ok) fail_now("bp_reach_row7");
    req = '0;
    ready_val = 1'b0;
`ifdef WRAM_STALL_CNT_EN
    stall0 = stall_count;
`endif
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("bp_valid", W'(row_valid), W'(1'b1));
      check("bp_index", W'(row_index), W'(7));
      check("bp_addr", W'(ram_address), W'(7));
      check("bp_data", row_data, rowval(7));
    end
`ifdef WRAM_STALL_CNT_EN
    check("bp_stall", W'(stall_count - stall0), W'(5));
`endif
    ready_val = 1'b1;
    wait_done(100);
    @(negedge clock);
    check("bp_busy_after", W'(busy), '0);

    // Request dropped mid-sweep still completes
    req = 4'b0100;
    push_sweep(req);
    rand_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clock);
      ok = row_valid && row_ready && row_index == 3;
    end
    if (!ok) fail_now("drop_reach_row3");
    req = '0;
    wait_done(1000);
    repeat (3) begin
      @(negedge clock);
      check("drop_idle_busy", W'(busy), '0);
      check("drop_idle_grant", W'(grant), '0);
    end

    // Random patterns and release styles
    for (int s = 0; s < 12; s++) begin
      @(negedge clock);
      pat = NREQ'($urandom_range(1, 15));
      req = pat;
      push_sweep(pat);
      rand_ready = 1'b1;
      if ($urandom_range(1) == 0) begin
        wait_grant(10);
        req = '0;
      end
      wait_done(1000);
      req = '0;
    end
    @(negedge clock);

    // Asynchronous reset at row 9
    @(negedge clock);
    req = 4'b1000;
    push_sweep(req);
    rand_ready = 1'b0;
    ready_val  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      ok = row_valid && row_index == 9;
    end
    if (!ok) fail_now("rst_reach_row9");
    #2;
    reset = 1'b0;
    #1;
    check("arst_grant", W'(grant), '0);
    check("arst_addr", W'(ram_address), '0);
    check("arst_data", row_data, '0);
    check("arst_index", W'(row_index), '0);
    check("arst_valid", W'(row_valid), '0);
    check("arst_done", W'(sweep_done), '0);
    check("arst_busy", W'(busy), '0);
`ifdef WRAM_STALL_CNT_EN
    check("arst_stall", W'(stall_count), '0);
`endif
    sb.delete();
    last_w = NREQ - 1;
    req = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    req = 4'b0010;
    push_sweep(req);
    wait_grant(10);
    check("arst_regrant", W'(grant), W'(4'b0010));
    check("arst_restart_addr", W'(ram_address), '0);
    req = '0;
    rand_ready = 1'b1;
    wait_done(1000);
    @(negedge clock);

`ifdef WRAM_STALL_CNT_EN
    // Saturation of the stall counter
    @(negedge clock);
    rand_ready = 1'b0;
    ready_val  = 1'b0;
    req = 4'b0001;
    push_sweep(req);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      ok = row_valid;
    end
    if (!ok) fail_now("sat_reach_row");
    req = '0;
    repeat (70000) @(negedge clock);
    check("sat_stall", W'(stall_count), W'(16'hFFFF));
    repeat (10) @(negedge clock);
    check("sat_hold", W'(stall_count), W'(16'hFFFF));
    ready_val = 1'b1;
    wait_done(100);
    @(negedge clock);
`endif

    @(negedge clock);
    check("sb_empty", W'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
